id_ex_decode_stage: RTL and testbench

- Next-generation decode/ID-EX register for the pipelined RV32I core.
- Decodes the full RV32I base integer set (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) into a registered control word, immediate and register indices.
- Adds hold-on-stall (contents kept, not zeroed), flush, and a load-use interlock with parametrised bubble count.
- Sits between the IF/ID register and the EX stage.

---
 rtl/core_pkg.sv | 72 +++++++
 rtl/imm_gen.sv | 28 ++
 rtl/id_ex_decode_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_id_ex_decode_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I decode constants: opcodes, ALU/regsrc codes, control-word bit map, immediate types.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_NONE   = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLL    = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_SLTU   = 4'b0101;
  localparam logic [3:0] ALU_XOR    = 4'b0110;
  localparam logic [3:0] ALU_SRL    = 4'b0111;
  localparam logic [3:0] ALU_SRA    = 4'b1000;
  localparam logic [3:0] ALU_OR     = 4'b1001;
  localparam logic [3:0] ALU_AND    = 4'b1010;
  localparam logic [3:0] ALU_PASS_B = 4'b1011;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam int CB_ALUOP    = 0;
  localparam int CB_BSEL     = 4;
  localparam int CB_ASEL     = 5;
  localparam int CB_BRANCH   = 8;
  localparam int CB_JAL      = 9;
  localparam int CB_MEMWRITE = 12;
  localparam int CB_MEMREAD  = 13;
  localparam int CB_REGSRC   = 16;
  localparam int CB_REGWRITE = 18;
  localparam int CB_FUNCT3   = 32;
  localparam int CB_JALR     = 35;
  localparam int CB_APC      = 36;
  localparam int CB_ILLEGAL  = 37;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  // alt selects SUB over ADD and SRA over SRL (funct7[5]).
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to XLEN; unknown opcodes give 0.
module imm_gen
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;
  logic        s;

  always_comb begin
    s   = instruction[31];
    raw = '0;
    case (imm_type_of(instruction[6:0]))
      IMM_I:   raw = {{20{s}}, instruction[31:20]};
      IMM_S:   raw = {{20{s}}, instruction[31:25], instruction[11:7]};
      IMM_B:   raw = {{20{s}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      IMM_U:   raw = {instruction[31:12], 12'b0};
      IMM_J:   raw = {{12{s}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/id_ex_decode_stage.sv
// RV32I decode + ID/EX register with hold-on-stall, flush and load-use interlock.
// Define ILLEGAL_TRAP_EN to flag unknown opcodes / reserved funct fields in ctrl[37].
module id_ex_decode_stage
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CTRL_W   = 40,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       instruction,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              stall,
  input  logic              pcsrc,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              hazard_stall
);

  typedef enum logic {RUN, INTERLOCK} state_e;

  state_e            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic              illegal, use_rs1, use_rs2, detect;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign f7     = instruction[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction (instruction),
    .imm         (dec_imm)
  );

  always_comb begin
    dec_ctrl = '0;
    illegal  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = alu_of(f3, f7[5]);
        dec_ctrl[CB_FUNCT3 +: 3]  = f3;
        use_rs2 = 1'b1;
        illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = alu_of(f3, (f3 == 3'b101) && f7[5]);
        dec_ctrl[CB_FUNCT3 +: 3]  = f3;
        illegal = (f3 == 3'b001 && f7 != 7'h00) ||
                  (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_LOAD: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_REGSRC +: 2]  = RS_MEM;
        dec_ctrl[CB_MEMREAD]      = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_ADD;
        dec_ctrl[CB_FUNCT3 +: 3]  = f3;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_ctrl[CB_MEMWRITE]     = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_ADD;
        dec_ctrl[CB_FUNCT3 +: 3]  = f3;
        use_rs2 = 1'b1;
        illegal = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec_ctrl[CB_BRANCH]       = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_SUB;
        dec_ctrl[CB_FUNCT3 +: 3]  = f3;
        use_rs2 = 1'b1;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_REGSRC +: 2]  = RS_PC4;
        dec_ctrl[CB_JAL]          = 1'b1;
        dec_ctrl[CB_APC]          = 1'b1;
        dec_ctrl[CB_ASEL]         = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_ADD;
      end
      OPC_JALR: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_REGSRC +: 2]  = RS_PC4;
        dec_ctrl[CB_JALR]         = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_ADD;
        dec_ctrl[CB_FUNCT3 +: 3]  = f3;
        illegal = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_ctrl[CB_REGWRITE]     = 1'b1;
        dec_ctrl[CB_APC]          = 1'b1;
        dec_ctrl[CB_ASEL]         = 1'b1;
        dec_ctrl[CB_BSEL]         = 1'b1;
        dec_ctrl[CB_ALUOP +: 4]   = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
`ifdef ILLEGAL_TRAP_EN
    if (illegal) begin
      dec_ctrl[CB_ILLEGAL]  = 1'b1;
      dec_ctrl[CB_REGWRITE] = 1'b0;
      dec_ctrl[CB_MEMREAD]  = 1'b0;
      dec_ctrl[CB_MEMWRITE] = 1'b0;
      dec_ctrl[CB_BRANCH]   = 1'b0;
      dec_ctrl[CB_JAL]      = 1'b0;
      dec_ctrl[CB_JALR]     = 1'b0;
    end
`endif
    if (!id_valid) dec_ctrl = '0;
  end

`ifndef ILLEGAL_TRAP_EN
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

  assign detect = (state == RUN) && ex_valid && ctrl[CB_MEMREAD] && (ex_rd != 5'd0) && id_valid &&
                  ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));

  // The detect cycle is the first bubble; INTERLOCK supplies the remaining LOAD_LAT-1.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hazard_stall = 1'b0;
    case (state)
      RUN: if (detect) begin
        hazard_stall = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt = INTERLOCK;
          cnt_nxt   = 2'(LOAD_LAT - 1);
        end
      end
      INTERLOCK: begin
        hazard_stall = 1'b1;
        if (cnt <= 2'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (stall) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end
    if (pcsrc) begin
      state_nxt    = RUN;
      cnt_nxt      = 2'd0;
      hazard_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || 1'b0) begin
      ex_valid <= 1'b0;
      ctrl     <= '0;
      imm      <= '0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (pcsrc || (!stall && hazard_stall)) begin
      ex_valid <= 1'b0;
      ctrl     <= '0;
      imm      <= '0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (!stall) begin
      ex_valid <= id_valid;
      ctrl     <= dec_ctrl;
      imm      <= dec_imm;
      ex_pc    <= id_pc;
      ex_rs1   <= rs1;
      ex_rs2   <= rs2;
      ex_rd    <= rd;
    end
  end

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed bench: two DUTs (LOAD_LAT 1 and 3) share stimulus; expectations are hand-computed.
module tb_id_ex_decode_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, pcsrc;
  logic [31:0] instruction, id_pc;

  logic        ev1, hs1, ev3, hs3;
  logic [39:0] c1, c3;
  logic [31:0] i1, pc1, i3, pc3;
  logic [4:0]  a1, b1, d1, a3, b3, d3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_decode_stage #(.XLEN(32), .CTRL_W(40), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction), .id_pc(id_pc),
    .stall(stall), .pcsrc(pcsrc), .ex_valid(ev1), .ctrl(c1), .imm(i1), .ex_pc(pc1),
    .ex_rs1(a1), .ex_rs2(b1), .ex_rd(d1), .hazard_stall(hs1)
  );

  id_ex_decode_stage #(.XLEN(32), .CTRL_W(40), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction), .id_pc(id_pc),
    .stall(stall), .pcsrc(pcsrc), .ex_valid(ev3), .ctrl(c3), .imm(i3), .ex_pc(pc3),
    .ex_rs1(a3), .ex_rs2(b3), .ex_rd(d3), .hazard_stall(hs3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    instruction = ins;
    id_pc       = pc;
    id_valid    = v;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #12;
    chk("rst_valid", ev1, 0);
    chk("rst_ctrl", c1, 0);
    chk("rst_imm", i1, 0);
    chk("rst_pc", pc1, 0);
    chk("rst_hazard", hs1, 0);
    rst = 1'b0;

    // addi x1,x0,-5
    drive(32'hFFB00093, 32'h100, 1'b1);
    tick();
    chk("addi_imm", i1, 32'hFFFFFFFB);
    chk("addi_rw", c1[18], 1);
    chk("addi_bsel", c1[4], 1);
    chk("addi_aluop", c1[3:0], 4'b0010);
    chk("addi_rd", d1, 1);
    chk("addi_valid", ev1, 1);
    chk("addi_pc", pc1, 32'h100);

    // beq x1,x2,-8
    drive(32'hFE208CE3, 32'h104, 1'b1);
    tick();
    chk("beq_imm", i1, 32'hFFFFFFF8);
    chk("beq_branch", c1[8], 1);
    chk("beq_bsel", c1[4], 0);
    chk("beq_aluop", c1[3:0], 4'b0001);
    chk("beq_f3", c1[34:32], 3'b000);
    chk("beq_rw", c1[18], 0);

    // sub x8,x6,x7
    drive(32'h40730433, 32'h108, 1'b1);
    tick();
    chk("sub_aluop", c1[3:0], 4'b0001);
    chk("sub_rw", c1[18], 1);
    chk("sub_bsel", c1[4], 0);

    // srai x9,x1,3
    drive(32'h4030D493, 32'h10C, 1'b1);
    tick();
    chk("srai_aluop", c1[3:0], 4'b1000);
    chk("srai_f3", c1[34:32], 3'b101);

    // lui x4,0x12345
    drive(32'h12345237, 32'h110, 1'b1);
    tick();
    chk("lui_imm", i1, 32'h12345000);
    chk("lui_aluop", c1[3:0], 4'b1011);

    // jal x1,+16
    drive(32'h010000EF, 32'h114, 1'b1);
    tick();
    chk("jal_imm", i1, 32'h10);
    chk("jal_bit", c1[9], 1);
    chk("jal_regsrc", c1[17:16], 2'b10);
    chk("jal_apc", c1[36], 1);

    drive(32'hFFB00093, 32'h118, 1'b0);
    tick();
    chk("novalid_valid", ev1, 0);
    chk("novalid_ctrl", c1, 0);

    drive(32'h0000007F, 32'h11C, 1'b1);
    tick();
    chk("ill_valid", ev1, 1);
    chk("ill_imm", i1, 0);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_flag", c1[37], 1);
    chk("ill_we", {c1[18], c1[13], c1[12], c1[8], c1[9], c1[35]}, 0);
`else
    chk("ill_ctrl", c1, 0);
`endif

    // sw x2,8(x1) held under stall
    drive(32'h0020A423, 32'h200, 1'b1);
    tick();
    chk("sw_memwrite", c1[12], 1);
    chk("sw_imm", i1, 8);
    stall = 1'b1;
    drive(32'h00700193, 32'h204, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_imm", i1, 8);
      chk("stall_mw", c1[12], 1);
      chk("stall_pc", pc1, 32'h200);
      chk("stall_f3", c1[34:32], 3'b010);
    end
    stall = 1'b0;
    tick();
    chk("release_rd", d1, 3);
    chk("release_pc", pc1, 32'h204);
    chk("release_mw", c1[12], 0);

    // asynchronous reset between edges
    #2; rst = 1'b1; #2;
    chk("arst_valid", ev1, 0);
    chk("arst_ctrl", c1, 0);
    chk("arst_imm", i1, 0);
    chk("arst_pc", pc1, 0);
    rst = 1'b0;

    // load-use, LOAD_LAT=1: lw x5,0(x1) then add x6,x5,x7
    pulse_rst();
    drive(32'h0000A283, 32'h300, 1'b1);
    tick();
    chk("lw_memread", c1[13], 1);
    chk("lw_rd", d1, 5);
    drive(32'h00728333, 32'h304, 1'b1);
    #1;
    chk("ll1_hazard", hs1, 1);
    tick();
    chk("ll1_bubble_valid", ev1, 0);
    chk("ll1_bubble_ctrl", c1, 0);
    chk("ll1_hazard_off", hs1, 0);
    tick();
    chk("ll1_add_valid", ev1, 1);
    chk("ll1_add_rs1", a1, 5);
    chk("ll1_add_rd", d1, 6);

    // LOAD_LAT=3 full interlock
    pulse_rst();
    drive(32'h0000A283, 32'h300, 1'b1);
    tick();
    drive(32'h00728333, 32'h304, 1'b1);
    #1;
    chk("ll3_detect", hs3, 1);
    tick();
    chk("ll3_b1", hs3, 1);
    tick();
    chk("ll3_b2", hs3, 1);
    tick();
    chk("ll3_done", hs3, 0);
    chk("ll3_b3_valid", ev3, 0);
    tick();
    chk("ll3_add_valid", ev3, 1);
    chk("ll3_add_rs1", a3, 5);

    // LOAD_LAT=3 with flush during the second bubble
    pulse_rst();
    drive(32'h0000A283, 32'h300, 1'b1);
    tick();
    drive(32'h00728333, 32'h304, 1'b1);
    #1;
    chk("fl_detect", hs3, 1);
    tick();
    chk("fl_b1", hs3, 1);
    pcsrc = 1'b1;
    #1;
    chk("fl_masked", hs3, 0);
    tick();
    chk("fl_valid", ev3, 0);
    chk("fl_ctrl", c3, 0);
    pcsrc = 1'b0;
    drive(32'h00700193, 32'h400, 1'b1);
    #1;
    chk("fl_run", hs3, 0);
    tick();
    chk("fl_next_valid", ev3, 1);
    chk("fl_next_rd", d3, 3);
    chk("fl_next_pc", pc3, 32'h400);

    // reset in the middle of INTERLOCK
    pulse_rst();
    drive(32'h0000A283, 32'h300, 1'b1);
    tick();
    drive(32'h00728333, 32'h304, 1'b1);
    tick();
    chk("mid_il", hs3, 1);
    pulse_rst();
    #1;
    chk("mid_rst_hazard", hs3, 0);
    tick();
    chk("mid_add_valid", ev3, 1);
    chk("mid_add_rd", d3, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
